// File: rtl/output_gen_demux_if.sv
// Handshake/bus bundle for the output generator demux: event inputs,
// configuration and the demultiplexed waveform outputs.
interface output_gen_demux_if #(
  parameter int unsigned PW_WIDTH = 8
) ();

  logic                enable_i;
  logic                match_i;
  logic                overflow_i;
  logic [1:0]          out_mode_i;
  logic [PW_WIDTH-1:0] pulse_width_i;
  logic [3:0]          output_sel_i;
  logic [15:1]         output_o;
  logic                sw_out_o;
  logic                busy_o;

  // Driver side (stimulus / surrounding timer logic)
  modport master (
    output enable_i, match_i, overflow_i, out_mode_i, pulse_width_i, output_sel_i,
    input  output_o, sw_out_o, busy_o
  );

  // Generator side
  modport slave (
    input  enable_i, match_i, overflow_i, out_mode_i, pulse_width_i, output_sel_i,
    output output_o, sw_out_o, busy_o
  );

endinterface

// File: rtl/output_gen_demux.sv
// Timer output generator: turns compare-match / overflow events into a
// waveform (set, clear, toggle or fixed-width retriggerable pulse) and routes
// it to one of 16 registered destinations.
module output_gen_demux #(
  parameter int unsigned PW_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output_gen_demux_if.slave    bus
);

  typedef enum logic {StIdle, StPulse} state_e;

  state_e              state_q, state_d;
  logic                wave_q, wave_d;
  logic [PW_WIDTH-1:0] cnt_q, cnt_d;
  logic [PW_WIDTH-1:0] load_val;
  logic [15:1]         out_q, out_d;
  logic                sw_q, sw_d;

  // A zero width is stretched to a single-cycle pulse
  assign load_val = (bus.pulse_width_i == '0) ? PW_WIDTH'(1) : bus.pulse_width_i;

  // Next waveform level, pulse FSM and counter
  always_comb begin
    state_d = state_q;
    wave_d  = wave_q;
    cnt_d   = cnt_q;
    if (!bus.enable_i) begin
      state_d = StIdle;
      wave_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          unique case (bus.out_mode_i)
            2'b00: begin
              if (bus.match_i)         wave_d = 1'b1;
              else if (bus.overflow_i) wave_d = 1'b0;
            end
            2'b01: begin
              if (bus.match_i)         wave_d = 1'b0;
              else if (bus.overflow_i) wave_d = 1'b1;
            end
            2'b10: begin
              if (bus.match_i) wave_d = ~wave_q;
            end
            default: begin
              if (bus.match_i) begin
                state_d = StPulse;
                wave_d  = 1'b1;
                cnt_d   = load_val;
              end
            end
          endcase
        end
        StPulse: begin
          // A pulse always runs to completion; only a pulse-mode match retriggers it
          if ((bus.out_mode_i == 2'b11) && bus.match_i) begin
            cnt_d = load_val;
          end else if (cnt_q == PW_WIDTH'(1)) begin
            state_d = StIdle;
            wave_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - PW_WIDTH'(1);
          end
        end
        default: begin
          state_d = StIdle;
          wave_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Demux of the next waveform level onto the selected destination only
  always_comb begin
    out_d = '0;
    sw_d  = 1'b0;
    if (bus.output_sel_i == 4'd0) sw_d = wave_d;
    else                          out_d[bus.output_sel_i] = wave_d;
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      wave_q  <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wave_q  <= wave_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      sw_q    <= sw_d;
    end
  end

  assign bus.output_o = out_q;
  assign bus.sw_out_o = sw_q;
  assign bus.busy_o   = (state_q == StPulse);

endmodule

// File: tb/tb_output_gen_demux.sv
// Scoreboard bench for output_gen_demux: stimulus pushes the reference model's
// expected outputs per clock edge; a monitor pops and compares after each edge.
module tb_output_gen_demux;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  output_gen_demux_if #(.PW_WIDTH(8)) bus_if ();

  output_gen_demux #(.PW_WIDTH(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  always #5 clk_i = ~clk_i;

  // Expected {output_o[15:1], sw_out_o, busy_o} after each driven edge
  logic [16:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: waveform level plus the edge index at which a pulse ends
  bit level     = 1'b0;
  int pulse_end = -1;

  // Current configuration
  bit       cur_en   = 1'b0;
  bit [1:0] cur_mode = 2'b00;
  int       cur_w    = 0;
  int       cur_sel  = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [16:0] pack_exp(bit lvl, int sel, bit busy);
    logic [15:1] o;
    logic        s;
    o = '0;
    s = 1'b0;
    if (sel == 0) s = lvl;
    else          o[sel] = lvl;
    return {o, s, busy};
  endfunction

  task automatic check(string name, logic [16:0] got, logic [16:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got out=%h sw=%b busy=%b, expected out=%h sw=%b busy=%b",
                  name, $time, got[16:2], got[1], got[0], exp[16:2], exp[1], exp[0]);
  endtask

  // Drive one cycle of inputs and predict the result of the following edge
  task automatic step(bit m, bit o);
    int c;
    int len;
    bit busy_before;
    @(negedge clk_i);
    bus_if.enable_i      = cur_en;
    bus_if.match_i       = m;
    bus_if.overflow_i    = o;
    bus_if.out_mode_i    = cur_mode;
    bus_if.pulse_width_i = 8'(cur_w);
    bus_if.output_sel_i  = 4'(cur_sel);
    c   = cyc + 1;
    len = (cur_w == 0) ? 1 : cur_w;
    busy_before = (pulse_end >= c);
    if (!cur_en) begin
      level     = 1'b0;
      pulse_end = -1;
    end else if (busy_before) begin
      if (cur_mode == 2'b11 && m) pulse_end = c + len;
      level = (c < pulse_end);
    end else begin
      case (cur_mode)
        2'b00: if (m) level = 1'b1; else if (o) level = 1'b0;
        2'b01: if (m) level = 1'b0; else if (o) level = 1'b1;
        2'b10: if (m) level = ~level;
        default: if (m) begin pulse_end = c + len; level = 1'b1; end
      endcase
    end
    exp_q.push_back(pack_exp(level, cur_sel, c < pulse_end));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Monitor: every edge with a pending prediction is compared
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("edge", {bus_if.output_o, bus_if.sw_out_o, bus_if.busy_o}, e);
      end
    end
  end

  initial begin
    bus_if.enable_i      = 1'b0;
    bus_if.match_i       = 1'b0;
    bus_if.overflow_i    = 1'b0;
    bus_if.out_mode_i    = 2'b00;
    bus_if.pulse_width_i = '0;
    bus_if.output_sel_i  = '0;
    #2;
    check("reset_state", {bus_if.output_o, bus_if.sw_out_o, bus_if.busy_o}, 17'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Set/clear on selected bit 5
    cur_en = 1'b1; cur_mode = 2'b00; cur_sel = 5;
    idle(3); step(1'b1, 1'b0); idle(9); step(1'b0, 1'b1); idle(3);

    // Pulse W=4 on sw_out, then W=0
    cur_mode = 2'b11; cur_w = 4; cur_sel = 0;
    step(1'b1, 1'b0); idle(6);
    cur_w = 0;
    step(1'b1, 1'b0); idle(3);

    // Retrigger two cycles in, no low gap
    cur_w = 4;
    step(1'b1, 1'b0); idle(1); step(1'b1, 1'b0); idle(6);

    // Maximum width, no wrap
    cur_w = 255;
    step(1'b1, 1'b0); idle(258);

    // Toggle on bit 3, then move to bit 7 mid-run
    cur_mode = 2'b10; cur_sel = 3;
    step(1'b1, 1'b0); idle(1); step(1'b1, 1'b0); idle(1); step(1'b1, 1'b0); idle(1);
    cur_sel = 7; idle(2);
    cur_sel = 3; step(1'b1, 1'b0); idle(1);

    // Clear mode, simultaneous events: match wins
    cur_mode = 2'b01; cur_sel = 9;
    step(1'b0, 1'b1); idle(1); step(1'b1, 1'b1); idle(1);
    step(1'b0, 1'b1);
    cur_en = 1'b0; step(1'b1, 1'b1);
    cur_en = 1'b1; step(1'b0, 1'b1); idle(2);

    // Mode change during pulse: pulse completes
    cur_mode = 2'b11; cur_w = 5; cur_sel = 12;
    step(1'b1, 1'b0);
    cur_mode = 2'b10; step(1'b1, 1'b0); idle(5); step(1'b1, 1'b0); idle(2);

    // Async reset mid-pulse
    cur_mode = 2'b11; cur_w = 6; cur_sel = 0;
    step(1'b1, 1'b0); idle(2);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 check("async_reset", {bus_if.output_o, bus_if.sw_out_o, bus_if.busy_o}, 17'd0);
    level = 1'b0; pulse_end = -1;
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1'b1, 1'b0); idle(8);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) cur_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)  cur_sel  = $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0)  cur_w    = $urandom_range(0, 7);
      cur_en = ($urandom_range(0, 24) != 0);
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    end

    @(negedge clk_i);
    @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
